// File: rtl/ct_ebiu_ncwt_ctrl.sv
// ct_ebiu_ncwt_ctrl: NCWT entry allocation, AW issue-order tracking and PIU B-response arbitration (EBIU_NCWT_FIXED_PRIO_EN selects fixed-priority arbitration)
module ct_ebiu_ncwt_ctrl #(
  parameter int NUM_ENTRY = 8,
  parameter int IDX_W = 3,
  parameter int ID_W = 8
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           ncq_ncwt_create_req,
  input  logic                           ncq_ncwt_aw_needissue,
  output logic                           ncwt_ncq_create_gnt,
  output logic [IDX_W-1:0]               ncwt_ncq_create_idx,
  output logic [NUM_ENTRY-1:0]           ncwt_create_en,
  output logic [NUM_ENTRY-1:0]           ncwt_create_dp_en,
  input  logic                           ncq_ncwt_wdata_done,
  input  logic [IDX_W-1:0]               ncq_ncwt_wdata_idx,
  output logic [NUM_ENTRY-1:0]           ncwt_wdata_create_en,
  input  logic [NUM_ENTRY-1:0]           ncwt_vld,
  input  logic [NUM_ENTRY-1:0]           ncwt_bvalid,
  input  logic [NUM_ENTRY*(ID_W+2)-1:0]  ncwt_bus,
  input  logic                           bfifo_pop_vld,
  output logic                           bfifo_pop_en,
  output logic [NUM_ENTRY-1:0]           ncwt_bus_bresp_updt_en,
  output logic [NUM_ENTRY-1:0]           ncwt_bresp_accept_en,
  output logic                           ncwt_piu_bvalid,
  output logic [ID_W-1:0]                ncwt_piu_bid,
  output logic [1:0]                     ncwt_piu_bresp,
  output logic [3:0]                     ncwt_piu_sel,
  input  logic                           piu_ncwt_bready,
  output logic                           ncwt_full,
  output logic                           ncwt_order_err
);
  localparam int BW = ID_W + 2;
  logic [IDX_W-1:0] free_idx;
  logic             free_any;
  // lowest-index free entry
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (!ncwt_vld[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
  end
  assign ncwt_ncq_create_gnt  = ncq_ncwt_create_req & free_any & ~cpurst;
  assign ncwt_ncq_create_idx  = cpurst ? '0 : free_idx;
  assign ncwt_create_en       = ncwt_ncq_create_gnt ? (NUM_ENTRY'(1) << free_idx) : '0;
  assign ncwt_create_dp_en    = ncwt_create_en;
  assign ncwt_full            = &ncwt_vld & ~cpurst;
  assign ncwt_wdata_create_en = (ncq_ncwt_wdata_done & ~cpurst) ? (NUM_ENTRY'(1) << ncq_ncwt_wdata_idx) : '0;
  logic [IDX_W-1:0] fifo_mem [NUM_ENTRY];
  logic [IDX_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, push, pop;
  assign fifo_empty             = wr_ptr == rd_ptr;
  assign push                   = ncwt_ncq_create_gnt & ncq_ncwt_aw_needissue;
  assign pop                    = bfifo_pop_vld & ~fifo_empty & ~cpurst;
  assign bfifo_pop_en           = pop;
  assign ncwt_bus_bresp_updt_en = pop ? (NUM_ENTRY'(1) << fifo_mem[rd_ptr[IDX_W-1:0]]) : '0;
  // order FIFO storage: entry indices in AW issue order
  always_ff @(posedge forever_cpuclk)
    if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= free_idx;
  // order FIFO pointers and sticky underflow flag
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ncwt_order_err <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr + (IDX_W+1)'(push);
      rd_ptr         <= rd_ptr + (IDX_W+1)'(pop);
      ncwt_order_err <= ncwt_order_err | (bfifo_pop_vld & fifo_empty);
    end
  end
  logic [IDX_W-1:0] arb_base, arb_idx;
  logic             arb_any, load;
  logic [BW-1:0]    win_word;
  logic [ID_W-1:0]  win_id;
  assign load = (~ncwt_piu_bvalid | piu_ncwt_bready) & arb_any & ~cpurst;
`ifdef EBIU_NCWT_FIXED_PRIO_EN
  assign arb_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  assign arb_base = rr_ptr;
  // round-robin pointer moves just past the last winner
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) rr_ptr <= '0;
    else if (load) rr_ptr <= arb_idx + IDX_W'(1);
  end
`endif
  // first pending entry at or after arb_base, wrapping
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    for (int k = NUM_ENTRY - 1; k >= 0; k--)
      if (ncwt_bvalid[arb_base + IDX_W'(k)]) begin
        arb_any = 1'b1;
        arb_idx = arb_base + IDX_W'(k);
      end
  end
  assign ncwt_bresp_accept_en = load ? (NUM_ENTRY'(1) << arb_idx) : '0;
  assign win_word             = ncwt_bus[arb_idx*BW +: BW];
  assign win_id               = win_word[BW-1:2];
  // PIU B output register; payload held until accepted
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ncwt_piu_bvalid <= 1'b0;
      ncwt_piu_bid    <= '0;
      ncwt_piu_bresp  <= '0;
      ncwt_piu_sel    <= '0;
    end else if (load) begin
      ncwt_piu_bvalid <= 1'b1;
      ncwt_piu_bid    <= win_id;
      ncwt_piu_bresp  <= win_word[1:0];
      ncwt_piu_sel    <= (4'b0001 << win_id[6:5]) | {4{win_id[7]}};
    end else if (piu_ncwt_bready) ncwt_piu_bvalid <= 1'b0;
  end
endmodule

// File: tb/tb_ct_ebiu_ncwt_ctrl.sv
// tb_ct_ebiu_ncwt_ctrl: vector table, directed corner sequences and randomized run against a queue-based model
module tb_ct_ebiu_ncwt_ctrl;
  logic clk = 1'b0;
  logic rst, req, aw, wd, bpv, brdy;
  logic [2:0] wdi;
  logic [7:0] vld, bv;
  logic [79:0] bus;
  logic gnt, pop_en, pbv, full, oerr;
  logic [2:0] cidx;
  logic [7:0] cen, cdp, wden, updt, acc, bid;
  logic [1:0] bresp;
  logic [3:0] sel;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ct_ebiu_ncwt_ctrl dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .ncq_ncwt_create_req(req), .ncq_ncwt_aw_needissue(aw),
    .ncwt_ncq_create_gnt(gnt), .ncwt_ncq_create_idx(cidx),
    .ncwt_create_en(cen), .ncwt_create_dp_en(cdp),
    .ncq_ncwt_wdata_done(wd), .ncq_ncwt_wdata_idx(wdi), .ncwt_wdata_create_en(wden),
    .ncwt_vld(vld), .ncwt_bvalid(bv), .ncwt_bus(bus),
    .bfifo_pop_vld(bpv), .bfifo_pop_en(pop_en), .ncwt_bus_bresp_updt_en(updt),
    .ncwt_bresp_accept_en(acc), .ncwt_piu_bvalid(pbv), .ncwt_piu_bid(bid),
    .ncwt_piu_bresp(bresp), .ncwt_piu_sel(sel), .piu_ncwt_bready(brdy),
    .ncwt_full(full), .ncwt_order_err(oerr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req = 0; aw = 0; wd = 0; wdi = 0; bpv = 0; brdy = 0; vld = 0; bv = 0;
  endtask

  task automatic do_reset;
    rst = 1; idle; bus = '0;
    tick; tick;
    rst = 0;
  endtask

  function automatic logic [3:0] sel_of(input logic [7:0] id);
    logic [3:0] s;
    s = 4'(1 << ((id >> 5) & 3));
    if (id >= 8'd128) s = 4'hF;
    return s;
  endfunction

  typedef struct {
    logic [7:0] vld; logic req; logic wd; logic [2:0] wdi;
    logic gnt; logic [2:0] idx; logic [7:0] en; logic full; logic [7:0] wden;
  } vec_t;
  vec_t tv[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] vacc;
    tv[0] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 8'h01, 1'b0, 8'h00};
    tv[1] = '{8'h01, 1'b1, 1'b1, 3'd6, 1'b1, 3'd1, 8'h02, 1'b0, 8'h40};
    tv[2] = '{8'h0F, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 8'h10, 1'b0, 8'h00};
    tv[3] = '{8'h7F, 1'b1, 1'b1, 3'd7, 1'b1, 3'd7, 8'h80, 1'b0, 8'h80};
    tv[4] = '{8'hFF, 1'b1, 1'b0, 3'd3, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00};
    tv[5] = '{8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h01};
    tv[6] = '{8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    tv[7] = '{8'hA5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd1, 8'h02, 1'b0, 8'h04};
    tv[8] = '{8'hFE, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 8'h01, 1'b0, 8'h00};
    tv[9] = '{8'h5B, 1'b1, 1'b1, 3'd5, 1'b1, 3'd2, 8'h04, 1'b0, 8'h20};

    // reset state
    do_reset;
    rst = 1; tick; #2;
    chk("rst_bvalid", pbv, 0); chk("rst_err", oerr, 0); chk("rst_pop", pop_en, 0);
    chk("rst_accept", acc, 0); chk("rst_gnt", gnt, 0); chk("rst_updt", updt, 0);
    rst = 0;

    // combinational vector table
    foreach (tv[n]) begin
      tick;
      idle; vld = tv[n].vld; req = tv[n].req; wd = tv[n].wd; wdi = tv[n].wdi;
      #2;
      chk($sformatf("tv%0d_gnt", n), gnt, tv[n].gnt);
      if (tv[n].gnt) chk($sformatf("tv%0d_idx", n), cidx, tv[n].idx);
      chk($sformatf("tv%0d_en", n), cen, tv[n].en);
      chk($sformatf("tv%0d_dp", n), cdp, tv[n].en);
      chk($sformatf("tv%0d_full", n), full, tv[n].full);
      chk($sformatf("tv%0d_wden", n), wden, tv[n].wden);
    end

    // fill all entries, then drain order FIFO, then underflow
    do_reset;
    vacc = 0;
    for (int c = 0; c < 9; c++) begin
      tick; idle; vld = vacc; req = 1; aw = 1; #2;
      chk($sformatf("fill%0d_gnt", c), gnt, c < 8);
      chk($sformatf("fill%0d_en", c), cen, c < 8 ? (1 << c) : 0);
      if (c < 8) begin
        chk($sformatf("fill%0d_idx", c), cidx, c);
        vacc[c] = 1'b1;
      end else chk("fill_full", full, 1);
    end
    for (int c = 0; c < 8; c++) begin
      tick; idle; vld = vacc; bpv = 1; #2;
      chk($sformatf("drain%0d_pop", c), pop_en, 1);
      chk($sformatf("drain%0d_updt", c), updt, 1 << c);
    end
    tick; idle; bpv = 1; #2;
    chk("under_pop", pop_en, 0); chk("under_updt", updt, 0); chk("under_err_pre", oerr, 0);
    for (int c = 0; c < 3; c++) begin
      tick; idle; #2;
      chk($sformatf("err_hold%0d", c), oerr, 1);
    end
    rst = 1; tick; #2;
    chk("err_clear", oerr, 0);
    rst = 0;

    // creates 2,5,3 then three pops follow issue order
    do_reset;
    tick; idle; vld = 8'hFB; req = 1; aw = 1; #2; chk("ord_c2", cidx, 2);
    tick; idle; vld = 8'hDF; req = 1; aw = 1; #2; chk("ord_c5", cidx, 5);
    tick; idle; vld = 8'hF7; req = 1; aw = 1; #2; chk("ord_c3", cidx, 3);
    tick; idle; bpv = 1; #2; chk("ord_p0", updt, 8'h04);
    tick; idle; bpv = 1; #2; chk("ord_p1", updt, 8'h20);
    tick; idle; bpv = 1; #2; chk("ord_p2", updt, 8'h08);

    // create without AW is never pushed
    do_reset;
    tick; idle; vld = 8'h00; req = 1; aw = 0; #2; chk("naw_c0", gnt, 1);
    tick; idle; vld = 8'h01; req = 1; aw = 1; #2; chk("naw_c1", cidx, 1);
    tick; idle; vld = 8'h03; bpv = 1; #2; chk("naw_updt", updt, 8'h02);
    tick; idle; vld = 8'h03; bpv = 1; #2; chk("naw_empty", pop_en, 0);

    // all entries pending, bready held high
    do_reset;
    for (int c = 0; c < 9; c++) begin
      tick; idle; bv = 8'hFF; brdy = 1; #2;
`ifdef EBIU_NCWT_FIXED_PRIO_EN
      chk($sformatf("arb%0d", c), acc, 8'h01);
`else
      chk($sformatf("arb%0d", c), acc, 1 << (c % 8));
`endif
      if (c > 0) chk($sformatf("arb%0d_bv", c), pbv, 1);
    end

    // backpressure holds payload; one accept pulse
    do_reset;
    bus[39:30] = {8'hA5, 2'b01};
    tick; idle; bv = 8'h08; #2;
    chk("bp_acc0", acc, 8'h08); chk("bp_bv0", pbv, 0);
    for (int c = 1; c <= 5; c++) begin
      tick; idle; brdy = (c == 5); #2;
      chk($sformatf("bp%0d_bv", c), pbv, 1);
      chk($sformatf("bp%0d_bid", c), bid, 8'hA5);
      chk($sformatf("bp%0d_resp", c), bresp, 2'b01);
      chk($sformatf("bp%0d_sel", c), sel, 4'hF);
      chk($sformatf("bp%0d_acc", c), acc, 0);
    end
    tick; idle; #2; chk("bp_drop", pbv, 0);
    tick; idle; bv = 8'h08; #2; chk("mid_acc", acc, 8'h08);
    tick; idle; #2; chk("mid_bv", pbv, 1);
    rst = 1; tick; #2; chk("mid_rst_bv", pbv, 0);
    rst = 0;

    // randomized run against queue model
    do_reset;
    begin
      logic [7:0] m_vld, m_bv, m_id, e_en, e_acc, bid_a [8];
      logic [1:0] m_br, br_a [8];
      logic m_ov, m_err, e_gnt, e_pop, ld_ok, inq;
      int q[$];
      int rr, w, a;
      m_vld = 0; m_bv = 0; m_ov = 0; m_err = 0; m_id = 0; m_br = 0; rr = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        tick;
        req = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
        wd = 1'($urandom_range(0, 1)); wdi = 3'($urandom_range(0, 7));
        bpv = ($urandom_range(0, 3) == 0); brdy = ($urandom_range(0, 3) != 0);
        vld = m_vld; bv = m_bv;
        for (int i = 0; i < 8; i++) begin
          bid_a[i] = 8'($urandom); br_a[i] = 2'($urandom);
          bus[i*10 +: 10] = {bid_a[i], br_a[i]};
        end
        #2;
        w = -1;
        for (int i = 7; i >= 0; i--) if (!m_vld[i]) w = i;
        e_gnt = req && (w >= 0);
        e_en = e_gnt ? 8'(1 << w) : 8'h00;
        chk("r_gnt", gnt, e_gnt); chk("r_en", cen, e_en); chk("r_dp", cdp, e_en);
        if (e_gnt) chk("r_idx", cidx, w);
        chk("r_full", full, m_vld == 8'hFF);
        chk("r_wden", wden, wd ? (1 << wdi) : 0);
        e_pop = bpv && (q.size() > 0);
        chk("r_pop", pop_en, e_pop);
        chk("r_updt", updt, e_pop ? (1 << q[0]) : 0);
        chk("r_err", oerr, m_err);
        ld_ok = !m_ov || brdy;
        a = -1;
        if (ld_ok)
          for (int k = 7; k >= 0; k--) if (m_bv[(rr + k) % 8]) a = (rr + k) % 8;
        e_acc = (a >= 0) ? 8'(1 << a) : 8'h00;
        chk("r_acc", acc, e_acc);
        chk("r_bv", pbv, m_ov);
        if (m_ov) begin
          chk("r_bid", bid, m_id); chk("r_resp", bresp, m_br); chk("r_sel", sel, sel_of(m_id));
        end
        if (bpv && q.size() == 0) m_err = 1;
        if (e_pop) void'(q.pop_front());
        if (e_gnt && aw) q.push_back(w);
        if (a >= 0) begin
          m_ov = 1; m_id = bid_a[a]; m_br = br_a[a];
`ifndef EBIU_NCWT_FIXED_PRIO_EN
          rr = (a + 1) % 8;
`endif
        end else if (brdy) m_ov = 0;
        m_bv = (m_bv & ~e_acc) | (8'($urandom) & 8'($urandom) & m_vld);
        m_vld = m_vld | e_en;
        for (int i = 0; i < 8; i++) begin
          inq = 0;
          foreach (q[j]) if (q[j] == i) inq = 1;
          if (m_vld[i] && !inq && !m_bv[i] && $urandom_range(0, 3) == 0) m_vld[i] = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ct_ebiu_ncwt_ctrl.md
Name: ct_ebiu_ncwt_ctrl

Overview:
- Controller for the EBIU non-cacheable write table (NCWT) entry array.
- Allocates free entries to NCQ write requests and records bus AW issue order so bus B responses steer to the correct entry.
- Arbitrates entry bvalid toward a single registered PIU B-response channel.
- Generates all per-entry strobes: create_en, create_dp_en, wdata_create_en, bus_bresp_updt_en, bresp_accept_en.

Parameters:
- NUM_ENTRY, 8, number of NCWT entries; also the order-FIFO depth.
- IDX_W, 3, entry index width (log2 NUM_ENTRY).
- ID_W, 8, AXI write ID width carried in each entry's bus word.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous active-high reset.
- ncq_ncwt_create_req  in  1  NCQ requests a new entry.
- ncq_ncwt_aw_needissue  in  1  AW of this create goes to bus (B expected).
- ncwt_ncq_create_gnt  out  1  entry granted this cycle.
- ncwt_ncq_create_idx  out  IDX_W  granted entry index.
- ncwt_create_en  out  NUM_ENTRY  one-hot create strobe.
- ncwt_create_dp_en  out  NUM_ENTRY  datapath gate enable; equals ncwt_create_en.
- ncq_ncwt_wdata_done  in  1  W data of an entry completed.
- ncq_ncwt_wdata_idx  in  IDX_W  entry whose W completed.
- ncwt_wdata_create_en  out  NUM_ENTRY  one-hot decode of wdata_idx.
- ncwt_vld  in  NUM_ENTRY  entry valid vector.
- ncwt_bvalid  in  NUM_ENTRY  entry response pending.
- ncwt_bus  in  NUM_ENTRY*(ID_W+2)  per-entry {id, bresp}; entry i at bits [(i+1)*10-1 : i*10].
- bfifo_pop_vld  in  1  bus B FIFO non-empty.
- bfifo_pop_en  out  1  pop bus B FIFO.
- ncwt_bus_bresp_updt_en  out  NUM_ENTRY  one-hot to order-FIFO head entry.
- ncwt_bresp_accept_en  out  NUM_ENTRY  one-hot to arbitration winner.
- ncwt_piu_bvalid  out  1  B response valid.
- ncwt_piu_bid  out  ID_W  response ID.
- ncwt_piu_bresp  out  2  response code.
- ncwt_piu_sel  out  4  PIU select: (1 << id[6:5]) | {4{id[7]}}.
- piu_ncwt_bready  in  1  PIU accepts response.
- ncwt_full  out  1  all entries valid.
- ncwt_order_err  out  1  sticky: B popped with empty order FIFO.

Behaviour:
- Reset: all outputs 0, order FIFO empty, RR pointer 0, output register empty, ncwt_order_err 0.
- Allocation (combinational, same cycle as req):
  - free = ~ncwt_vld; winner = lowest-index free entry.
  - gnt = req & |free; create_en = gnt ? onehot(winner) : 0.
  - ncwt_full = &ncwt_vld.
  - req while full -> gnt 0, no strobe; NCQ holds req.
- Order FIFO (NUM_ENTRY deep, stores IDX_W indices):
  - Push winner index when gnt & aw_needissue.
  - bfifo_pop_en = bfifo_pop_vld & fifo_not_empty.
  - On pop: bus_bresp_updt_en = onehot(head); head pointer advances.
  - Pointers wrap modulo NUM_ENTRY with an extra wrap bit for full/empty.
  - Simultaneous push and pop: both take effect; count unchanged.
  - Push into a full FIFO cannot occur, because allocation is bounded by NUM_ENTRY.
  - bfifo_pop_vld while FIFO empty -> no pop, ncwt_order_err set until reset.
- wdata_create_en = ncq_ncwt_wdata_done ? onehot(wdata_idx) : 0. No validity check.
- Response arbitration, output register stage:
  - load_ok = !ncwt_piu_bvalid | piu_ncwt_bready.
  - If load_ok & |ncwt_bvalid: pick round-robin winner starting at rr_ptr; assert bresp_accept_en[w]; register bid/bresp/sel from that entry's bus word; bvalid <= 1; rr_ptr <= w+1 mod NUM_ENTRY.
  - Else if bready: bvalid <= 0.
  - Latency: entry bvalid to ncwt_piu_bvalid is 1 cycle. Back-to-back responses sustain 1 per cycle while bready = 1.
  - The output payload is stable while bvalid & !bready.
  - Because accept_en clears the entry's bvalid on the next edge, an entry is never accepted twice.
- Synchronous reset mid-operation clears everything next edge. Any in-flight response in the output register is discarded.

Optional Feature:
- EBIU_NCWT_FIXED_PRIO_EN
  - Defined: response arbitration is fixed priority, lowest index wins; rr_ptr is removed.
  - Undefined (default): round-robin as above.

Test Plan:
- Reset, then req=1 for 9 cycles with aw_needissue=1 and all vld following create -> grants idx 0..7 on cycles 1..8, cycle 9 gnt=0 and full=1.
- Create entries 2, 5, 3 in order, then bfifo_pop_vld=1 for 3 cycles -> bus_bresp_updt_en = 0x04, 0x20, 0x08 in order.
- Create with aw_needissue=0 for idx 0, then idx 1 with aw_needissue=1; one B pop -> updt_en = 0x02, idx 0 never strobed.
- ncwt_bvalid=0xFF held with bready=1 -> accept_en sequence 0x01, 0x02, ... 0x80, 0x01. With EBIU_NCWT_FIXED_PRIO_EN and bvalid held -> 0x01 every cycle.
- Entry 3 bus word id=0xA5, bresp=2'b01; bready=0 for 4 cycles then 1 -> bvalid=1 from cycle 1, bid=0xA5, bresp=01, sel=4'b1111 stable; single accept_en pulse 0x08.
- bfifo_pop_vld=1 with empty order FIFO -> bfifo_pop_en=0, order_err=1 and held; cpurst=1 -> order_err=0 next edge.
